// File: rtl/if_prefetch.sv
// Instruction prefetch unit: owns the PC, issues one fetch per cycle into a
// fixed-latency instruction memory, and buffers responses in a small queue
// that decode drains with a valid/ready handshake. Redirects, interrupts and
// exceptions flush the queue and restart fetching at the new PC.
//
// Handshake: an entry moves to decode on any cycle where out_valid and
// out_ready are both 1. out_valid does not depend on out_ready. A flush in
// the same cycle still counts the head as consumed, but the queue is emptied.
module if_prefetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000,
    parameter logic [ADDR_W-1:0]  IRQ_VEC  = 32'h8000_0004,
    parameter logic [ADDR_W-1:0]  EXC_VEC  = 32'h8000_0008
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INST_W-1:0]           imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_target,
    input  logic [1:0]                  status,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_pc_plus4,
    output logic [INST_W-1:0]           out_inst,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // PC and the single outstanding fetch
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] fetch_pc4_q;   // PC+4 of the fetch whose data arrives now
    logic              fetch_live_q;  // 0 means "kill": no response is pushed
    logic              sys_mode_q;    // set by interrupt/exception, cleared by redirect

    // Queue storage and bookkeeping
    logic [ADDR_W-1:0] q_pc4  [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              flush;
    logic              push;
    logic              pop;
    logic              has_room;
    logic [ADDR_W-1:0] flush_target;
    logic [ADDR_W-1:0] flush_pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] push_pc4;

    // Flush target selection: interrupt beats exception beats redirect
    always_comb begin
        flush = redirect_valid || (status != 2'b00);
        if (status[1]) begin
            flush_target = IRQ_VEC;
        end else if (status[0]) begin
            flush_target = EXC_VEC;
        end else begin
            flush_target = redirect_target;
        end
        flush_pc = {flush_target[ADDR_W-1:2], 2'b00};
    end

    // Fetch issue, sequential PC increment and queue push/pop qualification
    always_comb begin
        // The top PC bit is a mode bit: the increment wraps below it.
        pc_inc    = {pc_q[ADDR_W-1], pc_q[ADDR_W-2:0] + (ADDR_W-1)'(4)};
        has_room  = (count_q + CNT_W'(fetch_live_q)) < CNT_W'(DEPTH);
        imem_req  = rst_n && has_room && !flush;
        imem_addr = pc_q;
        push      = fetch_live_q && !flush;
        pop       = out_valid && out_ready && !flush;
        push_pc4  = fetch_pc4_q;
        push_pc4[ADDR_W-1] = fetch_pc4_q[ADDR_W-1] | sys_mode_q;
    end

    assign out_valid    = (count_q != '0);
    assign occupancy    = count_q;
    assign out_pc_plus4 = q_pc4[rd_ptr_q];
    assign out_inst     = q_inst[rd_ptr_q];

    // PC, outstanding-fetch tracking and the sticky system-mode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            fetch_pc4_q  <= '0;
            fetch_live_q <= 1'b0;
            sys_mode_q   <= 1'b0;
        end else if (flush) begin
            pc_q         <= flush_pc;
            fetch_live_q <= 1'b0;
            sys_mode_q   <= (status != 2'b00);
        end else begin
            fetch_live_q <= imem_req;
            if (imem_req) begin
                pc_q        <= pc_inc;
                fetch_pc4_q <= pc_inc;
            end
        end
    end

    // Queue pointers and occupancy count; flush empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; cleared on reset so the head outputs read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc4[i]  <= '0;
                q_inst[i] <= '0;
            end
        end else if (push) begin
            q_pc4[wr_ptr_q]  <= push_pc4;
            q_inst[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
